ram_burst_master: RTL and testbench

RAM_BURST_MASTER -- requirements
Module: ram_burst_master

---
 rtl/ram_burst_pkg.sv | 18 +
 rtl/ram_burst_master.sv | 113 +++++++++++
 tb/tb_ram_burst_master.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_burst_pkg.sv
// Shared constants and FSM state encoding for the RAM burst master.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ram_burst_pkg;

  localparam int DATA_W = 8;   // RAM word width
  localparam int ADDR_W = 6;   // RAM address width
  localparam int DEPTH  = 64;  // words in the RAM

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD_ADDR = 3'd2,
    RD_DATA = 3'd3,
    DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/ram_burst_master.sv
// Burst master: turns a {dir, addr, len} command into a run of single-port RAM
// accesses. Writes take 1 cycle/beat and reads 2 cycles/beat; done pulses one cycle after the last beat.
// Backpressure: wdata_valid gaps stall the write burst, and rdata_ready low holds the current read beat.
// Ports: clk/rst_n; cmd_* command handshake; wdata_* write stream in;
//        rdata_* read stream out; busy/done status; ram_* drive the RAM.
module ram_burst_master #(
  parameter int DATA_W = ram_burst_pkg::DATA_W,
  parameter int ADDR_W = ram_burst_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rd,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              rdata_valid,
  input  logic              rdata_ready,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] ram_ip,
  output logic [ADDR_W-1:0] ram_add,
  output logic              ram_wr,
  input  logic [DATA_W-1:0] ram_q
);
  import ram_burst_pkg::*;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

  // RAM output is passed straight through; ram_add is held at addr for the
  // whole RD_DATA state, so the registered read word stays stable under stall.
  assign rdata = ram_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    cmd_ready   = 1'b0;
    wdata_ready = 1'b0;
    rdata_valid = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    ram_wr      = 1'b0;
    ram_ip      = '0;
    ram_add     = addr_q;

    unique case (state_q)
      IDLE: begin
        busy      = 1'b0;
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          cnt_d   = cmd_len;
          state_d = cmd_rd ? RD_ADDR : WR;
        end
      end

      WR: begin
        wdata_ready = 1'b1;
        ram_wr      = wdata_valid;
        ram_ip      = wdata;
        if (wdata_valid) begin
          addr_d = addr_q + ADDR_W'(1);  // natural wrap at 2**ADDR_W
          if (cnt_q == '0) state_d = DONE;
          else             cnt_d   = cnt_q - ADDR_W'(1);
        end
      end

      // One cycle with ram_wr low lets the RAM register addr; the word is
      // visible on ram_q from the following cycle.
      RD_ADDR: state_d = RD_DATA;

      RD_DATA: begin
        rdata_valid = 1'b1;
        if (rdata_ready) begin
          addr_d = addr_q + ADDR_W'(1);
          if (cnt_q == '0) begin
            state_d = DONE;
          end else begin
            cnt_d   = cnt_q - ADDR_W'(1);
            state_d = RD_ADDR;
          end
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ram_burst_master.sv
// Self-checking bench for ram_burst_master with a behavioural 64x8 single-port
// RAM behind the ram_* ports. Table-driven bursts plus hand-written corner
// sequences (read stall, gapped write, mid-burst reset, full 64-word sweep).
module tb_ram_burst_master;

  logic       clk, rst_n;
  logic       cmd_valid, cmd_ready, cmd_rd;
  logic [5:0] cmd_addr, cmd_len;
  logic       wdata_valid, wdata_ready;
  logic [7:0] wdata;
  logic       rdata_valid, rdata_ready;
  logic [7:0] rdata;
  logic       busy, done;
  logic [7:0] ram_ip;
  logic [5:0] ram_add;
  logic       ram_wr;
  logic [7:0] ram_q;

  int checks = 0;
  int errors = 0;

  ram_burst_master #(.DATA_W(8), .ADDR_W(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd(cmd_rd),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
    .busy(busy), .done(done),
    .ram_ip(ram_ip), .ram_add(ram_add), .ram_wr(ram_wr), .ram_q(ram_q)
  );

  // Single-port RAM: write on ram_wr, otherwise register the read address.
  logic [7:0] mem [64];
  logic [5:0] ram_add_q;
  always @(posedge clk) begin
    if (ram_wr) mem[ram_add] <= ram_ip;
    else        ram_add_q    <= ram_add;
  end
  assign ram_q = mem[ram_add_q];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0][7:0] d4(input logic [7:0] a, b, c, d);
    d4 = '0;
    d4[0] = a; d4[1] = b; d4[2] = c; d4[3] = d;
  endfunction

  function automatic logic [7:0][5:0] a4(input logic [5:0] a, b, c, d);
    a4 = '0;
    a4[0] = a; a4[1] = b; a4[2] = c; a4[3] = d;
  endfunction

  typedef struct packed {
    logic            rd;
    logic [5:0]      addr;
    logic [5:0]      len;
    logic [7:0][7:0] dat;      // write data / expected read data per beat
    logic [7:0][5:0] exp_add;  // expected ram_add per beat
  } vec_t;

  // Offers a command from IDLE; returns at the first cycle of the burst.
  task automatic do_cmd(input logic rd, input logic [5:0] a, input logic [5:0] len);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_rd = rd; cmd_addr = a; cmd_len = len;
    #1;
    chk("cmd_ready_idle", cmd_ready, 1);
    chk("busy_idle", busy, 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    chk("busy_after_cmd", busy, 1);
    chk("cmd_ready_busy", cmd_ready, 0);
  endtask

  task automatic wr_burst(input logic [5:0] a, input logic [5:0] len,
                          input logic [7:0][7:0] dat, input logic [7:0][5:0] ea,
                          input bit gap, input int abort_after);
    do_cmd(1'b0, a, len);
    for (int i = 0; i <= int'(len); i++) begin
      if (i == abort_after) begin
        wdata_valid = 1'b0;
        return;
      end
      if (gap) begin
        wdata_valid = 1'b0;
        #1;
        chk("wr_gap_ram_wr", ram_wr, 0);
        chk("wr_gap_busy", busy, 1);
        @(negedge clk); #1;
      end
      wdata_valid = 1'b1; wdata = dat[i];
      #1;
      chk("wr_wdata_ready", wdata_ready, 1);
      chk("wr_ram_wr", ram_wr, 1);
      chk("wr_ram_add", ram_add, ea[i]);
      chk("wr_ram_ip", ram_ip, dat[i]);
      chk("wr_done_early", done, 0);
      @(negedge clk); #1;
    end
    wdata_valid = 1'b0;
    #1;
    chk("wr_done_pulse", done, 1);
    chk("wr_done_busy", busy, 1);
    chk("wr_done_ram_wr", ram_wr, 0);
    @(negedge clk); #1;
    chk("wr_done_clear", done, 0);
    chk("wr_idle_busy", busy, 0);
    for (int i = 0; i <= int'(len); i++) chk("wr_mem", mem[ea[i]], dat[i]);
  endtask

  task automatic rd_burst(input logic [5:0] a, input logic [5:0] len,
                          input logic [7:0][7:0] dat, input logic [7:0][5:0] ea,
                          input int stall_beat, input int stall_cycles);
    do_cmd(1'b1, a, len);
    for (int i = 0; i <= int'(len); i++) begin
      rdata_ready = 1'b1;  // must be ignored in RD_ADDR
      #1;
      chk("rd_addr_valid", rdata_valid, 0);
      chk("rd_addr_ram_wr", ram_wr, 0);
      chk("rd_addr_ram_add", ram_add, ea[i]);
      @(negedge clk); #1;
      if (i == stall_beat) begin
        rdata_ready = 1'b0;
        for (int s = 0; s < stall_cycles; s++) begin
          #1;
          chk("rd_stall_valid", rdata_valid, 1);
          chk("rd_stall_data", rdata, dat[i]);
          @(negedge clk); #1;
        end
        rdata_ready = 1'b1;
      end
      #1;
      chk("rd_valid", rdata_valid, 1);
      chk("rd_data", rdata, dat[i]);
      chk("rd_ram_wr", ram_wr, 0);
      @(negedge clk); #1;
    end
    rdata_ready = 1'b0;
    #1;
    chk("rd_done_pulse", done, 1);
    chk("rd_done_valid", rdata_valid, 0);
    @(negedge clk); #1;
    chk("rd_done_clear", done, 0);
    chk("rd_idle_busy", busy, 0);
  endtask

  vec_t vecs [6];
  logic [7:0][7:0] gdat;
  logic [7:0][5:0] gadd;
  logic [5:0]      sweep_add;

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_rd = 1'b0; cmd_addr = '0; cmd_len = '0;
    wdata_valid = 1'b0; wdata = '0; rdata_ready = 1'b0;
    mem[42] = 8'hEE;

    vecs[0] = '{rd: 1'b0, addr: 6'd5,  len: 6'd3, dat: d4(8'hA0, 8'hA1, 8'hA2, 8'hA3), exp_add: a4(6'd5, 6'd6, 6'd7, 6'd8)};
    vecs[1] = '{rd: 1'b1, addr: 6'd5,  len: 6'd3, dat: d4(8'hA0, 8'hA1, 8'hA2, 8'hA3), exp_add: a4(6'd5, 6'd6, 6'd7, 6'd8)};
    vecs[2] = '{rd: 1'b0, addr: 6'd62, len: 6'd3, dat: d4(8'h11, 8'h22, 8'h33, 8'h44), exp_add: a4(6'd62, 6'd63, 6'd0, 6'd1)};
    vecs[3] = '{rd: 1'b1, addr: 6'd62, len: 6'd3, dat: d4(8'h11, 8'h22, 8'h33, 8'h44), exp_add: a4(6'd62, 6'd63, 6'd0, 6'd1)};
    vecs[4] = '{rd: 1'b0, addr: 6'd10, len: 6'd0, dat: d4(8'h5A, 8'h00, 8'h00, 8'h00), exp_add: a4(6'd10, 6'd0, 6'd0, 6'd0)};
    vecs[5] = '{rd: 1'b1, addr: 6'd10, len: 6'd0, dat: d4(8'h5A, 8'h00, 8'h00, 8'h00), exp_add: a4(6'd10, 6'd0, 6'd0, 6'd0)};

    // Reset state while rst_n is held low.
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ram_wr", ram_wr, 0);
    chk("rst_wdata_ready", wdata_ready, 0);
    chk("rst_rdata_valid", rdata_valid, 0);
    chk("rst_ram_add", ram_add, 0);
    chk("rst_ram_ip", ram_ip, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // wdata_valid in IDLE must not write.
    @(negedge clk);
    wdata_valid = 1'b1; wdata = 8'hFF;
    #1;
    chk("idle_wdata_ready", wdata_ready, 0);
    chk("idle_ram_wr", ram_wr, 0);
    wdata_valid = 1'b0;

    for (int v = 0; v < 6; v++) begin
      if (vecs[v].rd) rd_burst(vecs[v].addr, vecs[v].len, vecs[v].dat, vecs[v].exp_add, -1, 0);
      else            wr_burst(vecs[v].addr, vecs[v].len, vecs[v].dat, vecs[v].exp_add, 1'b0, -1);
    end

    // Read with beat 2 held for 5 cycles.
    rd_burst(6'd5, 6'd3, d4(8'hA0, 8'hA1, 8'hA2, 8'hA3), a4(6'd5, 6'd6, 6'd7, 6'd8), 1, 5);

    // 8-beat write with a gap before every beat, then read back.
    for (int i = 0; i < 8; i++) begin
      gdat[i] = 8'h60 + 8'(i);
      gadd[i] = 6'd20 + 6'(i);
    end
    wr_burst(6'd20, 6'd7, gdat, gadd, 1'b1, -1);
    rd_burst(6'd20, 6'd7, gdat, gadd, -1, 0);

    // Reset after 2 of 8 write beats.
    for (int i = 0; i < 8; i++) begin
      gdat[i] = 8'hC0 + 8'(i);
      gadd[i] = 6'd40 + 6'(i);
    end
    wr_burst(6'd40, 6'd7, gdat, gadd, 1'b0, 2);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_cmd_ready", cmd_ready, 1);
    chk("abort_done", done, 0);
    chk("abort_ram_wr", ram_wr, 0);
    chk("abort_wdata_ready", wdata_ready, 0);
    @(negedge clk); #1;
    chk("abort_done_late", done, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    chk("abort_mem42_kept", mem[42], 8'hEE);
    rd_burst(6'd40, 6'd1, d4(8'hC0, 8'hC1, 8'h00, 8'h00), a4(6'd40, 6'd41, 6'd0, 6'd0), -1, 0);

    // cmd_len=63 from address 30 sweeps all 64 words, last one at 29.
    do_cmd(1'b0, 6'd30, 6'd63);
    for (int i = 0; i < 64; i++) begin
      sweep_add = 6'd30 + 6'(i);
      wdata_valid = 1'b1; wdata = 8'(i);
      #1;
      chk("sweep_ram_add", ram_add, sweep_add);
      chk("sweep_ram_wr", ram_wr, 1);
      @(negedge clk); #1;
    end
    wdata_valid = 1'b0;
    #1;
    chk("sweep_done", done, 1);
    chk("sweep_mem29", mem[29], 8'd63);
    chk("sweep_mem30", mem[30], 8'd0);
    chk("sweep_mem0", mem[0], 8'd34);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
